// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, grant held per bus cycle, stall watchdog forces err
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS-1:0]    m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_wb_we_i,
    input  logic [4*NUM_MASTERS-1:0]  m_wb_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_wb_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_wb_dat_i,
    output logic [32*NUM_MASTERS-1:0] m_wb_dat_o,
    output logic [NUM_MASTERS-1:0]    m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]    m_wb_err_o,
    output logic                      s_wb_cyc_o,
    output logic                      s_wb_stb_o,
    output logic                      s_wb_we_o,
    output logic [3:0]                s_wb_sel_o,
    output logic [31:0]               s_wb_adr_o,
    output logic [31:0]               s_wb_dat_o,
    input  logic [31:0]               s_wb_dat_i,
    input  logic                      s_wb_ack_i,
    input  logic                      s_wb_err_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);
    localparam int N  = NUM_MASTERS;
    localparam int IW = N > 2 ? 2 : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IW-1:0]   gidx, last, nxt;
    logic            found, busy, mcyc, mask, stall;
    logic [TMO_W-1:0] cnt;

    assign busy = state == BUSY;
    assign mcyc = busy && m_wb_cyc_i[gidx];
    // On the Nth stalled strobe the slave strobe is withdrawn and err is returned instead
    assign mask = (TIMEOUT_CYCLES != 0) && busy && m_wb_stb_i[gidx] && cnt == TMO_W'(TIMEOUT_CYCLES - 1);

    assign s_wb_cyc_o = mcyc;
    assign s_wb_stb_o = busy && m_wb_stb_i[gidx] && !mask;
    assign s_wb_we_o  = busy && m_wb_we_i[gidx];
    assign s_wb_sel_o = busy ? m_wb_sel_i[4*gidx +: 4] : '0;
    assign s_wb_adr_o = busy ? m_wb_adr_i[32*gidx +: 32] : '0;
    assign s_wb_dat_o = busy ? m_wb_dat_i[32*gidx +: 32] : '0;
    assign stall      = s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i;

    always_comb begin
        m_wb_ack_o = '0;
        m_wb_err_o = '0;
        m_wb_dat_o = '0;
        if (mcyc) begin
            m_wb_ack_o[gidx] = s_wb_ack_i;
            m_wb_err_o[gidx] = s_wb_err_i || (mask && !s_wb_ack_i);
            m_wb_dat_o[32*gidx +: 32] = s_wb_dat_i;
        end
    end

    always_comb begin
        found = 1'b0;
        nxt   = last;
        for (int i = 1; i <= N; i++) begin
            if (!found && m_wb_cyc_i[(int'(last) + i) % N]) begin
                found = 1'b1;
                nxt   = IW'((int'(last) + i) % N);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            grant_o <= '0;
            gidx    <= '0;
            last    <= IW'(N - 1);
            cnt     <= '0;
        end else begin
            cnt <= !stall ? '0 : (cnt < TMO_W'(TIMEOUT_CYCLES) ? cnt + 1'b1 : cnt);
            if (state == IDLE) begin
                if (found) begin
                    state   <= BUSY;
                    gidx    <= nxt;
                    grant_o <= N'(1) << nxt;
                end
            end else if (!m_wb_cyc_i[gidx]) begin
                state   <= IDLE;
                last    <= gidx;
                grant_o <= '0;
            end
        end
    end
endmodule
